// File: rtl/fp8_accumulator.sv
// rtl/fp8_accumulator.sv - FP8 E4M3 dot-product accumulator with normalizing FP8 output
// Optional round-to-nearest-even output: define FP8_ACCUMULATOR_ROUND_EN (default build truncates).
module fp8_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  localparam int KW = $clog2(ACC_W);

`ifdef FP8_ACCUMULATOR_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  // Symmetric saturation limits, expressed one bit wider than acc for the raw sum.
  localparam logic signed [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ACC, NORM, OUT} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [ACC_W-2:0]  mag_q, mag_d;
  logic        [KW-1:0]     k_q, k_d;
  logic                     sign_q, sign_d;
  logic        [7:0]        out_data_q, out_data_d;

  logic        [3:0]        in_e;
  logic        [2:0]        in_m;
  logic        [ACC_W-1:0]  beat_mag;
  logic signed [ACC_W-1:0]  beat_val;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     acc_neg;
  logic        [ACC_W-1:0]  acc_abs;

  logic        [ACC_W-2:0]  mag_sh;
  logic        [KW-1:0]     k_sh;
  logic signed [8:0]        enc_exp;
  logic signed [8:0]        exp_r;
  logic        [2:0]        enc_man;
  logic        [2:0]        man_r;
  logic                     rnd_up;
  logic                     carry;
  logic        [7:0]        enc;

  assign in_e = in_data[6:3];
  assign in_m = in_data[2:0];

  // Decode the incoming beat to fixed point (LSB = 2^-9) and form the saturated running sum.
  always_comb begin
    beat_mag = '0;
    if (in_e != 4'd0) begin
      beat_mag = {{(ACC_W-4){1'b0}}, 1'b1, in_m} << (in_e - 4'd1);
    end
    beat_val = in_data[7] ? -beat_mag : beat_mag;
    sum      = {acc_q[ACC_W-1], acc_q} + {beat_val[ACC_W-1], beat_val};
    if (sum > SUM_MAX) begin
      acc_next = SUM_MAX[ACC_W-1:0];
    end else if (sum < SUM_MIN) begin
      acc_next = SUM_MIN[ACC_W-1:0];
    end else begin
      acc_next = sum[ACC_W-1:0];
    end
    acc_neg = acc_next[ACC_W-1];
    acc_abs = acc_neg ? -acc_next : acc_next;
  end

  // One normalization step and the FP8 encoding of the step's result.
  always_comb begin
    if (mag_q[ACC_W-2]) begin
      mag_sh = mag_q;
      k_sh   = k_q;
    end else begin
      mag_sh = mag_q << 1;
      k_sh   = k_q + {{(KW-1){1'b0}}, 1'b1};
    end
    enc_exp = 9'(ACC_W - 4) - 9'(k_sh);
    enc_man = mag_sh[ACC_W-3:ACC_W-5];
    rnd_up  = ROUND_EN & mag_sh[ACC_W-6] & ((|mag_sh[ACC_W-7:0]) | enc_man[0]);
    {carry, man_r} = {1'b0, enc_man} + {3'b000, rnd_up};
    exp_r   = enc_exp + 9'(carry);
    if (enc_exp < 9'sd1) begin
      enc = {sign_q, 7'h00};
    end else if (exp_r > 9'sd15) begin
      enc = {sign_q, 7'h7F};
    end else begin
      enc = {sign_q, exp_r[3:0], man_r};
    end
  end

  // Next-state logic: accumulate in ACC, normalize in NORM, hold the result in OUT.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mag_d      = mag_q;
    k_d        = k_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    in_ready   = (state_q == ACC);
    out_valid  = (state_q == OUT);
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = acc_next;
          if (in_last) begin
            mag_d  = acc_abs[ACC_W-2:0];
            sign_d = acc_neg;
            k_d    = '0;
            if (acc_abs == '0) begin
              out_data_d = 8'h00;
              state_d    = OUT;
            end else begin
              state_d = NORM;
            end
          end
        end
      end
      NORM: begin
        mag_d = mag_sh;
        k_d   = k_sh;
        if (mag_sh[ACC_W-2]) begin
          out_data_d = enc;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State registers; reset abandons any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      mag_q      <= '0;
      k_q        <= '0;
      sign_q     <= 1'b0;
      out_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mag_q      <= mag_d;
      k_q        <= k_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_fp8_accumulator.sv
// tb/tb_fp8_accumulator.sv - self-checking bench for fp8_accumulator
module tb_fp8_accumulator;

  localparam int W = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  fp8_accumulator #(.ACC_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct { logic [7:0] d; int rise; } res_t;
  res_t rq[$];
  int   rise_c = 0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && !ov_prev) rise_c = cyc;
    if (rst_n && out_valid && out_ready) rq.push_back('{out_data, rise_c});
    ov_prev = rst_n & out_valid;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: exact signed sum in 2^-9 units, clamped, then FP8 encode by leading-one search.
  function automatic void model(input logic [7:0] b[$], output logic [7:0] res, output int lat);
    longint lim = (longint'(1) << (W-1)) - 1;
    longint acc = 0;
    longint v, mag, mant4, rem, half;
    int p, e, man;
    logic s;
    foreach (b[i]) begin
      v = (b[i][6:3] == 4'd0) ? 0 : (longint'(8 + b[i][2:0]) << (b[i][6:3] - 1));
      if (b[i][7]) v = -v;
      acc = acc + v;
      if (acc > lim) acc = lim;
      if (acc < -lim) acc = -lim;
    end
    if (acc == 0) begin res = 8'h00; lat = 1; return; end
    s = (acc < 0);
    mag = s ? -acc : acc;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    lat = ((W - 2 - p) == 0) ? 2 : (W - 2 - p) + 1;
    e = p - 2;
    if (e < 1) begin res = {s, 7'h00}; return; end
    mant4 = mag >> (p - 3);
    man = int'(mant4) - 8;
`ifdef FP8_ACCUMULATOR_ROUND_EN
    if (p >= 4) begin
      rem = mag - (mant4 << (p - 3));
      half = longint'(1) << (p - 4);
      if (rem > half || (rem == half && man[0])) man++;
      if (man == 8) begin man = 0; e++; end
    end
`else
    rem = 0; half = 0;
`endif
    if (e > 15) res = {s, 7'h7F};
    else res = {s, e[3:0], man[2:0]};
  endfunction

  // Drive one beat; entered and left at a falling edge, in_valid stays high afterwards.
  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = b; in_last = last;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout in_ready=%0b expected=1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (last) last_acc = cyc;
  endtask

  task automatic send_pkt(input logic [7:0] b[$]);
    foreach (b[i]) send(b[i], i == b.size() - 1);
  endtask

  task automatic get_res(input string name, output res_t r, output bit ok);
    int n = 0;
    while (rq.size() == 0 && n < 300) begin @(negedge clk); n++; end
    ok = (rq.size() != 0);
    if (!ok) begin
      errors++; checks++;
      $display("FAIL %s_timeout results=0 expected=1", name);
      r = '{8'h00, 0};
    end else r = rq.pop_front();
  endtask

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] exp_t, exp_r;
    int         lat;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [7:0] pk[$];
    logic [7:0] exp_d, held;
    int exp_lat;
    res_t r;
    bit ok;

    vt.push_back('{1, 8'h38, 8'h00, 8'h00, 8'h00, 8'h38, 8'h38, 14});
    vt.push_back('{2, 8'h38, 8'hB8, 8'h00, 8'h00, 8'h00, 8'h00, 1});
    vt.push_back('{2, 8'h05, 8'h38, 8'h00, 8'h00, 8'h38, 8'h38, 14});
    vt.push_back('{2, 8'h38, 8'h3C, 8'h00, 8'h00, 8'h42, 8'h42, 13});
    vt.push_back('{2, 8'h3F, 8'h30, 8'h00, 8'h00, 8'h41, 8'h42, 13});
    vt.push_back('{4, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 4});
    vt.push_back('{4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4});
    vt.push_back('{2, 8'hB8, 8'h30, 8'h00, 8'h00, 8'hB0, 8'hB0, 15});
    vt.push_back('{1, 8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 20});
    vt.push_back('{1, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1});
    vt.push_back('{2, 8'h09, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00, 23});
    vt.push_back('{2, 8'h89, 8'h08, 8'h00, 8'h00, 8'h80, 8'h80, 23});
    vt.push_back('{1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h77, 8'h77, 7});

    // Reset values while reset is asserted
    #12;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vt[i]) begin
      pk = {vt[i].b0, vt[i].b1, vt[i].b2, vt[i].b3};
      pk = pk[0:vt[i].n-1];
      send_pkt(pk);
      in_valid = 1'b0;
`ifdef FP8_ACCUMULATOR_ROUND_EN
      exp_d = vt[i].exp_r;
`else
      exp_d = vt[i].exp_t;
`endif
      get_res($sformatf("vec%0d", i), r, ok);
      if (ok) begin
        chk($sformatf("vec%0d_data", i), int'(r.d), int'(exp_d));
        chk($sformatf("vec%0d_latency", i), r.rise - last_acc + 1, vt[i].lat);
      end
      @(negedge clk);
    end

    // Output stall: result held, no beats accepted
    out_ready = 1'b0;
    send(8'h38, 1'b1);
    in_valid = 1'b0;
    for (int n = 0; n < 300 && !out_valid; n++) @(negedge clk);
    chk("stall_valid", int'(out_valid), 1);
    held = out_data;
    chk("stall_data", int'(held), 8'h38);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", c), int'(out_data), int'(held));
      chk($sformatf("stall_in_ready%0d", c), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    get_res("stall", r, ok);
    if (ok) chk("stall_result", int'(r.d), 8'h38);
    @(negedge clk);

    // Back-to-back packets with in_valid held high across them
    send(8'h38, 1'b0);
    send(8'h38, 1'b1);
    send(8'h30, 1'b1);
    in_valid = 1'b0;
    get_res("b2b_a", r, ok);
    if (ok) chk("b2b_first", int'(r.d), 8'h40);
    get_res("b2b_b", r, ok);
    if (ok) chk("b2b_second", int'(r.d), 8'h30);
    @(negedge clk);

    // Reset pulse mid-normalization discards the pending result
    send(8'h38, 1'b1);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", int'(in_ready), 1);
    chk("midreset_out_valid", int'(out_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("midreset_no_result", rq.size(), 0);
    send(8'h38, 1'b1);
    in_valid = 1'b0;
    get_res("after_reset", r, ok);
    if (ok) chk("after_reset_data", int'(r.d), 8'h38);
    @(negedge clk);

    // Randomized packets against the reference model
    for (int i = 0; i < 40; i++) begin
      int len = (i % 10 == 9) ? 40 : $urandom_range(1, 5);
      pk = {};
      for (int j = 0; j < len; j++) begin
        logic [7:0] bb = 8'($urandom);
        if (i % 10 == 9) bb = {bb[7] & i[4], 4'hF, bb[2:0]};
        pk.push_back(bb);
      end
      model(pk, exp_d, exp_lat);
      send_pkt(pk);
      if ($urandom_range(0, 1) == 0) in_valid = 1'b0;
      get_res($sformatf("rnd%0d", i), r, ok);
      in_valid = 1'b0;
      if (ok) begin
        chk($sformatf("rnd%0d_data", i), int'(r.d), int'(exp_d));
        chk($sformatf("rnd%0d_latency", i), r.rise - last_acc + 1, exp_lat);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
